// File: rtl/mc_pkg.sv
// mc_pkg: shared state, ALU-op and select encodings for the multicycle ARM control unit.
package mc_pkg;
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctrl_t;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;
endpackage

// File: rtl/mc_control_unit_cond_check.sv
// cond_check: combinational ARM condition evaluation from Cond and stored NZCV flags.
module cond_check
   import mc_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_cond_ex
);
   logic w_n, w_z, w_c, w_v, w_ge;

   assign {w_n, w_z, w_c, w_v} = i_flags;
   assign w_ge = (w_n == w_v);

   // 1111 is treated as never-execute
   always_comb begin
      o_cond_ex = 1'b0;
      case (i_cond)
         COND_EQ: o_cond_ex = w_z;
         COND_NE: o_cond_ex = ~w_z;
         COND_CS: o_cond_ex = w_c;
         COND_CC: o_cond_ex = ~w_c;
         COND_MI: o_cond_ex = w_n;
         COND_PL: o_cond_ex = ~w_n;
         COND_VS: o_cond_ex = w_v;
         COND_VC: o_cond_ex = ~w_v;
         COND_HI: o_cond_ex = w_c & ~w_z;
         COND_LS: o_cond_ex = ~w_c | w_z;
         COND_GE: o_cond_ex = w_ge;
         COND_LT: o_cond_ex = ~w_ge;
         COND_GT: o_cond_ex = ~w_z & w_ge;
         COND_LE: o_cond_ex = w_z | ~w_ge;
         COND_AL: o_cond_ex = 1'b1;
         default: o_cond_ex = 1'b0;
      endcase
   end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle ARM-subset control FSM, ALU decode and NZCV flags.
// Optional MC_STALL_EN adds a stall input that holds the FSM in FETCH.
module mc_control_unit
   import mc_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
`ifdef MC_STALL_EN
   input  logic       stall,
`endif
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic       RegWrite,
   output logic [1:0] ALUControl,
   output logic [3:0] State
);
   state_t    r_state;
   logic [3:0] r_flags;
   logic      r_cond_ex;
   logic      w_cond_ex;
   logic      w_stall;
   logic      w_known;
   logic      w_arith;
   logic      w_exec;
   logic [1:0] w_flag_w;
   alu_ctrl_t w_dp_ctrl;

`ifdef MC_STALL_EN
   assign w_stall = stall;
`else
   assign w_stall = 1'b0;
`endif

   cond_check u_cond_check (
      .i_cond    (Cond),
      .i_flags   (r_flags),
      .o_cond_ex (w_cond_ex)
   );

   // unrecognised commands execute as ADD but never touch the flags
   assign w_dp_ctrl = (Funct[4:1] == 4'b0010) ? ALU_SUB :
                      (Funct[4:1] == 4'b0000) ? ALU_AND :
                      (Funct[4:1] == 4'b1100) ? ALU_ORR : ALU_ADD;
   assign w_arith   = (Funct[4:1] == 4'b0100) | (Funct[4:1] == 4'b0010);
   assign w_known   = w_arith | (Funct[4:1] == 4'b0000) | (Funct[4:1] == 4'b1100);
   assign w_flag_w  = {Funct[0] & w_known, Funct[0] & w_arith};
   assign w_exec    = (r_state == EXECR) | (r_state == EXECI);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= state_t'(RESET_STATE);
         r_flags   <= 4'b0000;
         r_cond_ex <= 1'b0;
      end else begin
         if (r_state == DECODE) r_cond_ex <= w_cond_ex;
         if (w_exec && r_cond_ex && w_flag_w[1]) r_flags[3:2] <= ALUFlags[3:2];
         if (w_exec && r_cond_ex && w_flag_w[0]) r_flags[1:0] <= ALUFlags[1:0];
         case (r_state)
            FETCH:        r_state <= w_stall ? FETCH : DECODE;
            DECODE:       r_state <= (Op == 2'b00) ? (Funct[5] ? EXECI : EXECR) :
                                     (Op == 2'b01) ? MEMADR :
                                     (Op == 2'b10) ? BRANCH : FETCH;
            MEMADR:       r_state <= Funct[0] ? MEMRD : MEMWR;
            MEMRD:        r_state <= MEMWB;
            EXECR, EXECI: r_state <= ALUWB;
            default:      r_state <= FETCH;
         endcase
      end
   end

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_RD2;
      ALUControl = ALU_ADD;
      case (r_state)
         FETCH: begin
            IRWrite   = ~w_stall;
            PCWrite   = ~w_stall;
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
         end
         MEMADR: ALUSrcB = SRCB_IMM;
         MEMRD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = r_cond_ex;
         end
         MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = r_cond_ex;
         end
         EXECR: ALUControl = w_dp_ctrl;
         EXECI: begin
            ALUSrcB    = SRCB_IMM;
            ALUControl = w_dp_ctrl;
         end
         ALUWB: begin
            RegWrite = r_cond_ex;
            PCWrite  = r_cond_ex & (Rd == 4'd15);
         end
         BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURES;
            PCWrite   = r_cond_ex;
         end
         default: ;
      endcase
      // enables must drop the instant reset asserts, not at the next edge
      if (reset) begin
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
      end
   end

   assign ImmSrc = Op;
   assign RegSrc = {Op == 2'b10, Op == 2'b01};
   assign State  = r_state;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed instruction sequences checked cycle by cycle against a scoreboard.
module tb_mc_control_unit;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond, Rd, ALUFlags;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
   logic [3:0] State;
`ifdef MC_STALL_EN
   logic       stall;
`endif

   typedef struct {
      string       tag;
      logic [15:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mc_control_unit dut (
      .clk        (clk),
      .reset      (reset),
`ifdef MC_STALL_EN
      .stall      (stall),
`endif
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .RegWrite   (RegWrite),
      .ALUControl (ALUControl),
      .State      (State)
   );

   // {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
   function automatic logic [15:0] ev(input int st, pcw, adr, mw, irw, rw, rs, sa, sbs, alc);
      return {st[3:0], pcw[0], adr[0], mw[0], irw[0], rw[0], rs[1:0], sa[0], sbs[1:0], alc[1:0]};
   endfunction

   task automatic push(input string t, input logic [15:0] v);
      exp_t x;
      x.tag = t;
      x.v   = v;
      sb.push_back(x);
   endtask

   task automatic cmp();
      exp_t        e;
      logic [15:0] got;
      #1;
      e   = sb.pop_front();
      got = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl};
      n_tests++;
      assert (got === e.v) else begin
         n_fail++;
         $error("FAIL %s got=%h exp=%h", e.tag, got, e.v);
      end
   endtask

   task automatic run();
      while (sb.size() > 0) begin
         cmp();
         @(negedge clk);
      end
   endtask

   task automatic ins(input logic [31:0] i, input logic [3:0] f);
      Cond     = i[31:28];
      Op       = i[27:26];
      Funct    = i[25:20];
      Rd       = i[15:12];
      ALUFlags = f;
   endtask

   task automatic fd(input string t);
      push({t, ":F"}, ev(0, 1, 0, 0, 1, 0, 2, 1, 2, 0));
      push({t, ":D"}, ev(1, 0, 0, 0, 0, 0, 2, 1, 2, 0));
   endtask

   task automatic dp(input string t, input logic imm, input logic [1:0] alc, input logic c, input logic r15);
      fd(t);
      push({t, ":EX"}, ev(imm ? 7 : 6, 0, 0, 0, 0, 0, 0, 0, int'(imm), int'(alc)));
      push({t, ":WB"}, ev(8, int'(c & r15), 0, 0, 0, int'(c), 0, 0, 0, 0));
      run();
   endtask

   task automatic br(input string t, input logic c);
      fd(t);
      push({t, ":BR"}, ev(9, int'(c), 0, 0, 0, 0, 2, 0, 1, 0));
      run();
   endtask

   task automatic ldr(input string t, input logic c);
      fd(t);
      push({t, ":MA"}, ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      push({t, ":MR"}, ev(3, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      push({t, ":MB"}, ev(4, 0, 0, 0, 0, int'(c), 1, 0, 0, 0));
      run();
   endtask

   task automatic str(input string t, input logic c);
      fd(t);
      push({t, ":MA"}, ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      push({t, ":MW"}, ev(5, 0, 1, int'(c), 0, 0, 0, 0, 0, 0));
      run();
   endtask

   initial begin
      reset = 1'b1;
`ifdef MC_STALL_EN
      stall = 1'b0;
`endif
      ins(32'hE0821003, 4'h0);
      @(negedge clk);
      push("reset", ev(0, 0, 0, 0, 0, 0, 2, 1, 2, 0));
      cmp();
      reset = 1'b0;
      dp("add", 1'b0, 2'd0, 1'b1, 1'b0);
      ins(32'hE0521003, 4'h4);
      dp("subs_z", 1'b0, 2'd1, 1'b1, 1'b0);
      ins(32'hE0821003, 4'h0);
      dp("add_nos", 1'b0, 2'd0, 1'b1, 1'b0);
      ins(32'h0A000002, 4'h0);
      br("beq_taken", 1'b1);
      ins(32'hE0521003, 4'h0);
      dp("subs_clr", 1'b0, 2'd1, 1'b1, 1'b0);
      ins(32'h0A000002, 4'h0);
      br("beq_not", 1'b0);
      ins(32'hE5921000, 4'h0);
      ldr("ldr", 1'b1);
      ins(32'hE5821000, 4'h0);
      str("str", 1'b1);
      ins(32'hF5821000, 4'h0);
      str("str_nv", 1'b0);
      ins(32'hEC000000, 4'h0);
      fd("undef");
      run();
      ins(32'hE380F000, 4'h0);
      dp("orr_pc", 1'b1, 2'd3, 1'b1, 1'b1);
      ins(32'hF082F003, 4'h0);
      dp("add_nv", 1'b0, 2'd0, 1'b0, 1'b1);
      ins(32'hE1521003, 4'hF);
      dp("cmp_unk", 1'b0, 2'd0, 1'b1, 1'b0);
      ins(32'h0A000002, 4'h0);
      br("beq_unk", 1'b0);
      ins(32'hE0921003, 4'h2);
      dp("adds_c", 1'b0, 2'd0, 1'b1, 1'b0);
      ins(32'h2A000002, 4'h0);
      br("bcs", 1'b1);
      ins(32'h8A000002, 4'h0);
      br("bhi", 1'b1);
      ins(32'h9A000002, 4'h0);
      br("bls", 1'b0);
      ins(32'hE1921003, 4'h0);
      dp("orrs", 1'b0, 2'd3, 1'b1, 1'b0);
      ins(32'h2A000002, 4'h0);
      br("bcs_keep", 1'b1);
      ins(32'hE0521003, 4'h4);
      dp("subs_z2", 1'b0, 2'd1, 1'b1, 1'b0);
      ins(32'hE5821000, 4'h0);
      fd("str_rst");
      push("str_rst:MA", ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      run();
      push("str_rst:MW", ev(5, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      cmp();
      reset = 1'b1;
      push("rst_async", ev(0, 0, 0, 0, 0, 0, 2, 1, 2, 0));
      cmp();
      @(negedge clk);
      reset = 1'b0;
      ins(32'h0A000002, 4'h4);
      br("beq_postrst", 1'b0);
`ifdef MC_STALL_EN
      ins(32'hEC000000, 4'h0);
      stall = 1'b1;
      repeat (3) push("stall", ev(0, 0, 0, 0, 0, 0, 2, 1, 2, 0));
      run();
      stall = 1'b0;
      fd("post_stall");
      run();
`endif
      ins(32'hE0821003, 4'h0);
      dp("final", 1'b0, 2'd0, 1'b1, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle control unit for the ARM-subset datapath: one shared ALU, one unified memory, IR/Data/A/B/ALUOut registers.
- Sequences every instruction through fetch/decode/execute states.
- Decodes ALUControl and FlagW, owns the NZCV flags register and condition-check logic.
- Drives all datapath mux selects and write enables. Replaces the single-cycle decoder/cond-unit pair.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RD1(A), 1=PC
- ALUSrcB  out  2  00=RD2(B), 01=ExtImm, 10=constant 4
- ImmSrc  out  2  Op-based: 00 data-proc, 01 mem, 10 branch
- RegSrc  out  2  {Op==10, Op==01}
- RegWrite  out  1  register file write enable
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- State  out  4  current FSM state, for debug/bench

Behaviour:
- Reset (async): state=FETCH, Flags=0000, CondExReg=0. While reset is high, PCWrite, MemWrite, IRWrite and RegWrite are forced 0. All other outputs follow the FETCH decode.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Encodings 10–15 are illegal and go to FETCH next cycle with all enables 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (computes PC+8). CondExReg latches CondEx(Cond, Flags).
  - Op=00, Funct[5]=0 -> EXECR
  - Op=00, Funct[5]=1 -> EXECI
  - Op=01 -> MEMADR
  - Op=10 -> BRANCH
  - Op=11 -> FETCH
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
- MEMRD: AdrSrc=1. Next MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondExReg. Next FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondExReg. Next FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00. EXECI: ALUSrcA=0, ALUSrcB=01. Both next ALUWB.
  - ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other value = ADD with no flag write.
  - FlagW[1] (N,Z) = Funct[0]. FlagW[0] (C,V) = Funct[0] & (ADD|SUB).
  - Flags update at end of cycle only when the FlagW bit is set and CondExReg=1.
- ALUWB: ResultSrc=00, RegWrite=CondExReg. If Rd==15, PCWrite=CondExReg too. Next FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExReg. Next FETCH.
- CondEx table:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V
  - GT ~Z&(N==V), LE Z|(N!=V)
  - AL (1110) 1; 1111 = 0 (treated as not executed)
- Latency: data-processing 4 cycles, LDR 5, STR 4, B 3, undefined 2.
- Reset mid-instruction aborts it; no partial write after reset deasserts.

Optional Feature:
- Macro MC_STALL_EN.
- Defined: adds input port stall (1 bit). In FETCH with stall=1, the FSM holds FETCH and IRWrite=PCWrite=0. Other states ignore stall.
- Undefined: port absent; FETCH always advances.

Decomposition:
- Package mc_pkg holds:
  - state_t enum (encodings above)
  - alu_ctrl_t (ADD/SUB/AND/ORR)
  - cond codes as localparams
  - ResultSrc/ALUSrcB select constants
- Sub-module cond_check: combinational CondEx from Cond and Flags. Flags and CondExReg registers live in the top.

Test Plan:
- Reset: reset=1 mid-MEMWR -> State=0, MemWrite=0 immediately (async); Flags=0000. After release, State sequence 0,1,...
- ADD R1,R2,R3 (0xE0821003) -> States 0,1,6,8,0. ALUControl=00 in EXECR. RegWrite=1 only in ALUWB. Flags unchanged.
- SUBS R1,R2,R3 (0xE0521003) with ALUFlags=0100 in EXECR -> Flags=0100 after EXECR. Next BEQ (0x0A000002) -> PCWrite=1 in BRANCH.
- BEQ (0x0A000002) with Flags=0000 -> States 0,1,9,0. PCWrite=0 in BRANCH.
- LDR R1,[R2] (0xE5921000) -> States 0,1,2,3,4,0. AdrSrc=1 in MEMRD. RegWrite=1 and ResultSrc=01 in MEMWB. STR (0xE5821000) -> 0,1,2,5,0 with MemWrite=1 in MEMWR only.
- Op=11 (0xEC000000) -> States 0,1,0, no write enables. With MC_STALL_EN and stall=1 held for 3 cycles -> State stays 0 and IRWrite=0 throughout.
